calc_op_sequencer: RTL and testbench

Multi-cycle arithmetic sequencer sitting between the calculator input controller and the display path. Accepts two latched 16-bit signed operands plus a one-hot operator, schedules a single shared adder for add, subtract and iterative shift-add multiply, and returns a registered 16-bit two's-complement result with a one-cycle `done` pulse. The controller starts it on the equal press and holds the display on `result`.

---
 rtl/calc_pkg.sv | 8 +
 rtl/mul_shift_add_step.sv | 13 +
 rtl/calc_op_sequencer.sv | 101 ++++++++++
 tb/tb_calc_op_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: operator codes, sequencer states and datapath width shared by the calculator blocks
package calc_pkg;
  localparam int CALC_WIDTH = 16;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;
  typedef enum logic [1:0] {S_IDLE, S_ADDSUB, S_MUL, S_DONE} seq_state_t;
endpackage

// File: rtl/mul_shift_add_step.sv
// mul_shift_add_step: one combinational shift-add multiply iteration
module mul_shift_add_step
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic               i_bit,
  output logic [2*WIDTH-1:0] o_acc
);
  assign o_acc = i_acc + (i_bit ? i_mcand : '0);
endmodule

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: schedules add, subtract and shift-add multiply on one adder,
// returning a registered WIDTH-bit result with overflow/error flags and a done pulse
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             error
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  seq_state_t         r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_mplier, r_result;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [CW-1:0]      r_cnt;
  logic               r_neg, r_overflow, r_error;
  logic               w_accept, w_legal, w_mul_ovf;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next, w_prod;
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_legal  = op == OP_ADD || op == OP_SUB || op == OP_MUL;
  // Unsigned WIDTH-bit magnitude: the most negative value maps to 2^(WIDTH-1), which still fits
  assign w_mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign w_mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign w_sum = r_op == OP_SUB ? {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b}
                                : {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b};
  mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_bit   (r_mplier[r_cnt]),
    .o_acc   (w_acc_next)
  );
  assign w_prod = r_neg ? -w_acc_next : w_acc_next;
  // Product fits in signed WIDTH bits only if its upper bits are a pure sign extension
  assign w_mul_ovf = !(&w_prod[2*WIDTH-1:WIDTH-1] || !(|w_prod[2*WIDTH-1:WIDTH-1]));
  assign busy     = r_state == S_ADDSUB || r_state == S_MUL;
  assign done     = r_state == S_DONE;
  assign result   = r_result;
  assign overflow = r_overflow;
  assign error    = r_error;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_mplier   <= '0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op;
      r_a      <= operand_a;
      r_b      <= operand_b;
      r_mplier <= w_mag_b;
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      r_state  <= !w_legal ? S_DONE : (op == OP_MUL ? S_MUL : S_ADDSUB);
      if (!w_legal) begin
        r_result   <= '0;
        r_overflow <= 1'b0;
        r_error    <= 1'b1;
      end
    end else if (r_state == S_ADDSUB) begin
      r_result   <= w_sum[WIDTH-1:0];
      r_overflow <= w_sum[WIDTH] ^ w_sum[WIDTH-1];
      r_error    <= 1'b0;
      r_state    <= S_DONE;
    end else if (r_state == S_MUL) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_cnt   <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_result   <= w_prod[WIDTH-1:0];
        r_overflow <= w_mul_ovf;
        r_error    <= 1'b0;
        r_state    <= S_DONE;
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed and randomized checks of calc_op_sequencer against an arithmetic model
module tb_calc_op_sequencer;
  import calc_pkg::*;
  logic        clk = 1'b0, nRST = 1'b1, start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] operand_a = '0, operand_b = '0;
  logic        busy, done, overflow, error;
  logic [15:0] result;
  int n_tests = 0, n_fail = 0;

  calc_op_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .nRST(nRST), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .error(error)
  );

  always #5 clk = ~clk;

  // Exact signed arithmetic, truncated afterwards; latency in negedges after the accepting edge
  function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic ov, output logic er, output int lat);
    longint x, sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    er = 1'b0;
    if (o == 3'b001) begin x = sa + sb; lat = 2; end
    else if (o == 3'b010) begin x = sa - sb; lat = 2; end
    else if (o == 3'b100) begin x = sa * sb; lat = 17; end
    else begin x = 0; er = 1'b1; lat = 1; end
    r  = x[15:0];
    ov = !er && (x > 32767 || x < -32768);
  endfunction

  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 40);
  endtask

  task automatic test_reset();
    #2 nRST = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, result, overflow, error} !== 20'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, result, overflow, error});
    end
    nRST = 1'b1;
  endtask

  task automatic test_addsub();
    logic [2:0]  to [3] = '{OP_ADD, OP_SUB, OP_SUB};
    logic [15:0] ta [3] = '{16'd12, 16'd2, 16'h8000};
    logic [15:0] tb [3] = '{16'd31, 16'd9, 16'd1};
    logic [15:0] tr [3] = '{16'd43, 16'hFFF9, 16'h7FFF};
    logic        tv [3] = '{1'b0, 1'b0, 1'b1};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      issue(to[i], ta[i], tb[i]);
      wait_done(lat, bc);
      n_tests++;
      if (result !== tr[i]) begin n_fail++; $display("FAIL addsub_result[%0d]: got %h expected %h", i, result, tr[i]); end
      n_tests++;
      if (overflow !== tv[i]) begin n_fail++; $display("FAIL addsub_ovf[%0d]: got %b expected %b", i, overflow, tv[i]); end
      n_tests++;
      if (lat !== 2 || bc !== 1) begin n_fail++; $display("FAIL addsub_timing[%0d]: got lat %0d busy %0d expected 2 1", i, lat, bc); end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL addsub_done_pulse[%0d]: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_mul();
    logic [15:0] ta [4] = '{16'd11, 16'hFFFB, 16'd300, 16'h8000};
    logic [15:0] tb [4] = '{16'd12, 16'd7, 16'd300, 16'd1};
    logic [15:0] tr [4] = '{16'd132, 16'hFFDD, 16'h5F90, 16'h8000};
    logic        tv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      issue(OP_MUL, ta[i], tb[i]);
      wait_done(lat, bc);
      n_tests++;
      if (result !== tr[i] || overflow !== tv[i]) begin
        n_fail++; $display("FAIL mul[%0d]: got %h/%b expected %h/%b", i, result, overflow, tr[i], tv[i]);
      end
      n_tests++;
      if (lat !== 17 || bc !== 16) begin n_fail++; $display("FAIL mul_timing[%0d]: got lat %0d busy %0d expected 17 16", i, lat, bc); end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0, lat, bc;
    issue(OP_MUL, 16'd1000, 16'd3);
    repeat (8) @(negedge clk);
    nRST = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, result, overflow, error} !== 20'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", {busy, done, result, overflow, error});
    end
    @(negedge clk);
    nRST = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen); end
    issue(OP_ADD, 16'd1, 16'd2);
    wait_done(lat, bc);
    n_tests++;
    if (result !== 16'd3 || lat !== 2) begin n_fail++; $display("FAIL reset_mid_recover: got %h lat %0d expected 0003 lat 2", result, lat); end
  endtask

  task automatic test_illegal();
    int lat, bc;
    issue(3'b011, 16'd50, 16'd60);
    wait_done(lat, bc);
    n_tests++;
    if ({error, overflow, result} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL illegal_flags: got err %b ovf %b res %h expected 1 0 0000", error, overflow, result);
    end
    n_tests++;
    if (lat !== 1 || bc !== 0) begin n_fail++; $display("FAIL illegal_timing: got lat %0d busy %0d expected 1 0", lat, bc); end
    issue(OP_ADD, 16'd5, 16'd6);
    wait_done(lat, bc);
    n_tests++;
    if (error !== 1'b0 || result !== 16'd11) begin n_fail++; $display("FAIL illegal_clear: got err %b res %h expected 0 000b", error, result); end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    issue(OP_MUL, 16'd123, 16'hFFD3);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_ADD; operand_a = 16'd1; operand_b = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    n_tests++;
    if (result !== 16'hEA61 || 6 + lat !== 17) begin
      n_fail++; $display("FAIL ignore_start: got %h lat %0d expected ea61 lat 17", result, 6 + lat);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ignore_start_queued: got busy %b done %b expected 0 0", busy, done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    @(negedge clk);
    start = 1'b1; op = OP_ADD; operand_a = 16'd100; operand_b = 16'd23;
    @(negedge clk);
    op = OP_MUL; operand_a = 16'd7; operand_b = 16'd9;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || result !== 16'd123) begin n_fail++; $display("FAIL b2b_first: got done %b res %h expected 1 007b", done, result); end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    n_tests++;
    if (result !== 16'd63 || lat !== 17 || bc !== 16) begin
      n_fail++; $display("FAIL b2b_second: got %h lat %0d busy %0d expected 003f 17 16", result, lat, bc);
    end
  endtask

  task automatic test_random();
    logic [15:0] edges [5] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [15:0] a, b, er;
      logic        eo, ee;
      int          el, lat, bc;
      case ($urandom_range(0, 4))
        0: o = OP_ADD;
        1: o = OP_SUB;
        2, 3: o = OP_MUL;
        default: o = 3'($urandom);
      endcase
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
      model(o, a, b, er, eo, ee, el);
      issue(o, a, b);
      wait_done(lat, bc);
      n_tests++;
      if ({result, overflow, error} !== {er, eo, ee} || lat !== el) begin
        n_fail++;
        $display("FAIL random[%0d] op %b a %h b %h: got %h/%b/%b lat %0d expected %h/%b/%b lat %0d",
                 i, o, a, b, result, overflow, error, lat, er, eo, ee, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_reset_mid();
    test_illegal();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
